rocketcpu_bus_scheduler: RTL and testbench



---
 rtl/rocketcpu_bus_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_rocketcpu_bus_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_bus_scheduler.sv
// rocketcpu_bus_scheduler
// Round-robin Wishbone-classic scheduler for three masters (SERV ibus,
// SERV dbus, auxiliary DMA/debug) sharing one memory bus. A watchdog ends
// any transaction that no slave acknowledges, returns ERR_DATA and keeps
// error statistics so firmware never hangs on a dead address.
module rocketcpu_bus_scheduler #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        i_wb_clk,
    input  logic        reset_n,
    // master 0: instruction bus (read only)
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    // master 1: data bus
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    // master 2: auxiliary
    input  logic [31:0] i_aux_adr,
    input  logic [31:0] i_aux_dat,
    input  logic [3:0]  i_aux_sel,
    input  logic        i_aux_we,
    input  logic        i_aux_cyc,
    output logic [31:0] o_aux_rdt,
    output logic        o_aux_ack,
    // shared bus towards the address decoder
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    // error reporting
    output logic        o_bus_err,
    output logic [1:0]  o_err_master,
    output logic [7:0]  o_err_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Watchdog fires when the counter reaches this value in a BUSY cycle,
    // i.e. in the TIMEOUT-th BUSY cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_q;
    logic [7:0]  cnt_q;
    logic [1:0]  err_master_q;
    logic [7:0]  err_count_q;

    logic [2:0]  req;
    logic        req_any;
    logic [1:0]  grant_d;
    logic        busy;
    logic        gnt_cyc;
    logic        timeout_hit;
    logic        term;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;
    logic        m_we;
    logic [31:0] rdt_mux;

    assign req     = {i_aux_cyc, i_dbus_cyc, i_ibus_cyc};
    assign req_any = |req;

    // Round-robin pick: first requester strictly after the last grant.
    always_comb begin
        grant_d = 2'd0;
        case (last_q)
            2'd0:    grant_d = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    grant_d = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: grant_d = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Request mux from the granted master; ibus is a fixed full-word read.
    always_comb begin
        gnt_cyc = 1'b0;
        m_adr   = 32'd0;
        m_dat   = 32'd0;
        m_sel   = 4'd0;
        m_we    = 1'b0;
        case (grant_q)
            2'd0: begin
                gnt_cyc = i_ibus_cyc;
                m_adr   = i_ibus_adr;
                m_sel   = 4'hF;
            end
            2'd1: begin
                gnt_cyc = i_dbus_cyc;
                m_adr   = i_dbus_adr;
                m_dat   = i_dbus_dat;
                m_sel   = i_dbus_sel;
                m_we    = i_dbus_we;
            end
            2'd2: begin
                gnt_cyc = i_aux_cyc;
                m_adr   = i_aux_adr;
                m_dat   = i_aux_dat;
                m_sel   = i_aux_sel;
                m_we    = i_aux_we;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q == S_BUSY);
    // A real ack in the last watchdog cycle wins over the timeout.
    assign timeout_hit = busy & ~i_wb_ack & (cnt_q == CNT_LAST);
    assign term        = i_wb_ack | timeout_hit;

    // Shared bus drives zero outside a grant; cyc drops in the timeout
    // cycle so the slave sees the cycle end.
    assign o_wb_cyc = busy & ~timeout_hit;
    assign o_wb_adr = busy ? m_adr : 32'd0;
    assign o_wb_dat = busy ? m_dat : 32'd0;
    assign o_wb_sel = busy ? m_sel : 4'd0;
    assign o_wb_we  = busy & m_we;

    // Read data is only meaningful while a grant is active.
    assign rdt_mux    = !busy ? 32'd0 : (timeout_hit ? ERR_DATA : i_wb_rdt);
    assign o_ibus_rdt = rdt_mux;
    assign o_dbus_rdt = rdt_mux;
    assign o_aux_rdt  = rdt_mux;

    assign o_ibus_ack = busy & (grant_q == 2'd0) & term;
    assign o_dbus_ack = busy & (grant_q == 2'd1) & term;
    assign o_aux_ack  = busy & (grant_q == 2'd2) & term;

    assign o_bus_err    = timeout_hit;
    assign o_err_master = err_master_q;
    assign o_err_count  = err_count_q;

    // Scheduler FSM with watchdog counter and error statistics.
    always_ff @(posedge i_wb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'd0;
            last_q       <= 2'd2;
            cnt_q        <= 8'd0;
            err_master_q <= 2'd0;
            err_count_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        state_q <= S_BUSY;
                        grant_q <= grant_d;
                        last_q  <= grant_d;
                        cnt_q   <= 8'd0;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Completion, timeout or master abort all return to IDLE,
                    // which guarantees one idle cycle between transactions.
                    if (term || !gnt_cyc) begin
                        state_q <= S_IDLE;
                    end
                    if (timeout_hit) begin
                        err_master_q <= grant_q;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rocketcpu_bus_scheduler.sv
// Directed bench for rocketcpu_bus_scheduler: fetch, round-robin, watchdog
// timeout and saturation, ack on the timeout boundary, abort and
// asynchronous reset in the middle of a transaction.
module tb_rocketcpu_bus_scheduler;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] aux_adr;
    logic [31:0] aux_dat;
    logic [3:0]  aux_sel;
    logic        aux_we;
    logic        aux_cyc;
    logic [31:0] aux_rdt;
    logic        aux_ack;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        bus_err;
    logic [1:0]  err_master;
    logic [7:0]  err_count;
    logic [2:0]  ack_v;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rr_adr [3];

    assign ack_v = {aux_ack, dbus_ack, ibus_ack};

    always #5 clk = ~clk;

    rocketcpu_bus_scheduler #(
        .TIMEOUT  (TMO),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .i_wb_clk     (clk),
        .reset_n      (rst_n),
        .i_ibus_adr   (ibus_adr),
        .i_ibus_cyc   (ibus_cyc),
        .o_ibus_rdt   (ibus_rdt),
        .o_ibus_ack   (ibus_ack),
        .i_dbus_adr   (dbus_adr),
        .i_dbus_dat   (dbus_dat),
        .i_dbus_sel   (dbus_sel),
        .i_dbus_we    (dbus_we),
        .i_dbus_cyc   (dbus_cyc),
        .o_dbus_rdt   (dbus_rdt),
        .o_dbus_ack   (dbus_ack),
        .i_aux_adr    (aux_adr),
        .i_aux_dat    (aux_dat),
        .i_aux_sel    (aux_sel),
        .i_aux_we     (aux_we),
        .i_aux_cyc    (aux_cyc),
        .o_aux_rdt    (aux_rdt),
        .o_aux_ack    (aux_ack),
        .o_wb_adr     (wb_adr),
        .o_wb_dat     (wb_dat),
        .o_wb_sel     (wb_sel),
        .o_wb_we      (wb_we),
        .o_wb_cyc     (wb_cyc),
        .i_wb_rdt     (wb_rdt),
        .i_wb_ack     (wb_ack),
        .o_bus_err    (bus_err),
        .o_err_master (err_master),
        .o_err_count  (err_count)
    );

    // Count one comparison and report it if the observed value differs.
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int pulses;
        int guard;

        rr_adr[0] = 32'h0000_0100;
        rr_adr[1] = 32'h0000_0200;
        rr_adr[2] = 32'h0000_0300;

        rst_n    = 1'b0;
        ibus_adr = 32'd0;  ibus_cyc = 1'b1;
        dbus_adr = 32'd0;  dbus_dat = 32'h1111_2222; dbus_sel = 4'h0; dbus_we = 1'b0; dbus_cyc = 1'b1;
        aux_adr  = 32'd0;  aux_dat  = 32'd0; aux_sel = 4'h0; aux_we = 1'b0; aux_cyc = 1'b0;
        wb_rdt   = 32'hFFFF_FFFF;
        wb_ack   = 1'b1;

        // Reset state, with requests and slave signals active
        repeat (2) @(negedge clk);
        #1;
        chk_eq("rst_wb_cyc", wb_cyc, 0);
        chk_eq("rst_acks",   ack_v, 0);
        chk_eq("rst_wb_adr", wb_adr, 0);
        chk_eq("rst_rdt",    ibus_rdt, 0);
        chk_eq("rst_err",    bus_err, 0);
        chk_eq("rst_err_cnt", err_count, 0);
        chk_eq("rst_err_mst", err_master, 0);
        @(negedge clk);
        rst_n = 1'b1; ibus_cyc = 1'b0; dbus_cyc = 1'b0; wb_ack = 1'b0; wb_rdt = 32'd0;

        // Single fetch, slave acks in the 2nd BUSY cycle
        @(negedge clk);
        ibus_cyc = 1'b1; ibus_adr = 32'h0010_0000;
        #1 chk_eq("f_idle_cyc", wb_cyc, 0);
        @(negedge clk); #1;
        chk_eq("f_b1_cyc",  wb_cyc, 1);
        chk_eq("f_b1_adr",  wb_adr, 32'h0010_0000);
        chk_eq("f_b1_sel",  wb_sel, 4'hF);
        chk_eq("f_b1_we",   wb_we, 0);
        chk_eq("f_b1_dat",  wb_dat, 0);
        chk_eq("f_b1_acks", ack_v, 0);
        @(negedge clk);
        wb_ack = 1'b1; wb_rdt = 32'h1234_5678;
        #1;
        chk_eq("f_b2_cyc",  wb_cyc, 1);
        chk_eq("f_b2_acks", ack_v, 3'b001);
        chk_eq("f_b2_rdt",  ibus_rdt, 32'h1234_5678);
        @(negedge clk);
        wb_ack = 1'b0; ibus_cyc = 1'b0;
        #1;
        chk_eq("f_post_cyc",  wb_cyc, 0);
        chk_eq("f_post_acks", ack_v, 0);
        @(negedge clk); #1;
        chk_eq("f_stay_idle", wb_cyc, 0);

        // Round-robin with all masters requesting, 1-cycle slave
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        ibus_adr = rr_adr[0]; dbus_adr = rr_adr[1]; aux_adr = rr_adr[2];
        ibus_cyc = 1'b1; dbus_cyc = 1'b1; aux_cyc = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            wb_ack = 1'b1; wb_rdt = 32'hA000_0000 + t;
            #1;
            chk_eq($sformatf("rr%0d_adr", t), wb_adr, rr_adr[t % 3]);
            chk_eq($sformatf("rr%0d_ack", t), ack_v, 32'd1 << (t % 3));
            @(negedge clk);
            wb_ack = 1'b0;
            #1 chk_eq($sformatf("rr%0d_gap", t), wb_cyc, 0);
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; aux_cyc = 1'b0;

        // Timeout on a dbus write with no ack
        @(negedge clk);
        dbus_cyc = 1'b1; dbus_adr = 32'h0300_0000; dbus_dat = 32'hA5A5_0001;
        dbus_sel = 4'h3; dbus_we = 1'b1; wb_rdt = 32'h0000_0055;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            chk_eq($sformatf("to_b%0d_cyc", c), wb_cyc, 1);
            chk_eq($sformatf("to_b%0d_we", c),  {wb_we, wb_sel}, 5'h13);
            chk_eq($sformatf("to_b%0d_dat", c), wb_dat, 32'hA5A5_0001);
            chk_eq($sformatf("to_b%0d_ack", c), ack_v, 0);
            chk_eq($sformatf("to_b%0d_err", c), bus_err, 0);
        end
        @(negedge clk); #1;
        chk_eq("to_ack",     ack_v, 3'b010);
        chk_eq("to_err",     bus_err, 1);
        chk_eq("to_rdt",     dbus_rdt, 32'hDEAD_BEEF);
        chk_eq("to_cyc",     wb_cyc, 0);
        chk_eq("to_cnt_pre", err_count, 0);
        @(negedge clk);
        dbus_cyc = 1'b0; dbus_we = 1'b0;
        #1;
        chk_eq("to_cnt",      err_count, 1);
        chk_eq("to_mst",      err_master, 1);
        chk_eq("to_err_pulse", bus_err, 0);
        chk_eq("to_idle",     wb_cyc, 0);

        // Slave ack exactly in the TIMEOUT-th BUSY cycle
        @(negedge clk);
        aux_cyc = 1'b1; aux_adr = 32'h0400_0000; aux_we = 1'b0; aux_sel = 4'hF; aux_dat = 32'd0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        wb_ack = 1'b1; wb_rdt = 32'hCAFE_0004;
        #1;
        chk_eq("bd_ack", ack_v, 3'b100);
        chk_eq("bd_rdt", aux_rdt, 32'hCAFE_0004);
        chk_eq("bd_err", bus_err, 0);
        chk_eq("bd_cyc", wb_cyc, 1);
        @(negedge clk);
        wb_ack = 1'b0; aux_cyc = 1'b0;
        #1;
        chk_eq("bd_cnt", err_count, 1);
        chk_eq("bd_mst", err_master, 1);

        // 299 further timeouts saturate the error counter at 255
        @(negedge clk);
        dbus_cyc = 1'b1; dbus_we = 1'b1;
        pulses = 0;
        guard  = 0;
        while (pulses < 299 && guard < 3000) begin
            @(negedge clk); #1;
            if (bus_err) pulses++;
            guard++;
        end
        chk_eq("sat_pulses", pulses, 299);
        @(negedge clk);
        dbus_cyc = 1'b0; dbus_we = 1'b0;
        #1;
        chk_eq("sat_cnt", err_count, 255);
        chk_eq("sat_mst", err_master, 1);

        // Abort: granted aux drops cyc, pending ibus granted next
        @(negedge clk);
        aux_cyc = 1'b1; aux_adr = 32'h0500_0000; aux_we = 1'b1; aux_dat = 32'h0000_00AB;
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_0040;
        @(negedge clk); #1;
        chk_eq("ab_b1_adr", wb_adr, 32'h0500_0000);
        chk_eq("ab_b1_we",  wb_we, 1);
        @(negedge clk);
        aux_cyc = 1'b0;
        #1;
        chk_eq("ab_acks", ack_v, 0);
        chk_eq("ab_err",  bus_err, 0);
        @(negedge clk); #1;
        chk_eq("ab_gap_cyc",  wb_cyc, 0);
        chk_eq("ab_gap_acks", ack_v, 0);
        @(negedge clk);
        wb_ack = 1'b1; wb_rdt = 32'h0000_0777;
        #1;
        chk_eq("ab_next_adr", wb_adr, 32'h0000_0040);
        chk_eq("ab_next_ack", ack_v, 3'b001);
        chk_eq("ab_mst",      err_master, 1);
        @(negedge clk);
        wb_ack = 1'b0; ibus_cyc = 1'b0;

        // Asynchronous reset in the 2nd BUSY cycle of an aux write
        @(negedge clk);
        aux_cyc = 1'b1; aux_adr = 32'h0600_0000; aux_we = 1'b1;
        @(negedge clk);
        dbus_cyc = 1'b1; dbus_adr = rr_adr[1]; ibus_cyc = 1'b1; ibus_adr = rr_adr[0];
        @(negedge clk);
        wb_ack = 1'b1;
        #1;
        chk_eq("rm_pre_ack", ack_v, 3'b100);
        chk_eq("rm_pre_cyc", wb_cyc, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("rm_cyc",  wb_cyc, 0);
        chk_eq("rm_acks", ack_v, 0);
        chk_eq("rm_adr",  wb_adr, 0);
        chk_eq("rm_cnt",  err_count, 0);
        chk_eq("rm_mst",  err_master, 0);
        wb_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk_eq("rm_first_cyc", wb_cyc, 1);
        chk_eq("rm_first_adr", wb_adr, rr_adr[0]);
        chk_eq("rm_first_sel", wb_sel, 4'hF);
        @(negedge clk);
        wb_ack = 1'b1;
        #1 chk_eq("rm_first_ack", ack_v, 3'b001);
        @(negedge clk);
        wb_ack = 1'b0; ibus_cyc = 1'b0; dbus_cyc = 1'b0; aux_cyc = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
